ibex_instr_responder: RTL and testbench

//  Responder end of the Ibex instruction-fetch interface for the test-rig wrapper: accepts fetch requests
//  (req/gnt/rvalid), returns words from a local instruction store preloaded through a load port, flags
//  out-of-range fetches via err. Sits between the simulation environment and ibex_top instr_* ports.

---
 rtl/ibex_instr_responder.sv | 110 +++++++++++
 tb/tb_ibex_instr_responder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ibex_instr_responder.sv
// Responder side of the Ibex instruction-fetch port. It serves words from a local store that is
// preloaded through a load port, and returns responses in order through a small response FIFO.
module ibex_instr_responder #(
  parameter int unsigned Depth          = 256,
  parameter logic [31:0] BaseAddr       = 32'h8000_0000,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     instr_req_i,
  input  logic [31:0]              instr_addr_i,
  output logic                     instr_gnt_o,
  output logic                     instr_rvalid_o,
  output logic [31:0]              instr_rdata_o,
  output logic [6:0]               instr_rdata_intg_o,
  output logic                     instr_err_o,
  input  logic                     stall_i,
  input  logic                     load_we_i,
  input  logic [$clog2(Depth)-1:0] load_addr_i,
  input  logic [31:0]              load_data_i,
  output logic [15:0]              err_count_o
);

  localparam int unsigned IdxW   = $clog2(Depth);
  localparam int unsigned PtrW   = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [32:0] Span   = 33'(4 * Depth);
  localparam logic [2:0]  MaxCnt = 3'(MaxOutstanding);

  function automatic logic [6:0] secded_inv_enc(input logic [31:0] d);
    logic [6:0] c;
    c[0] = ^(d & 32'h2606_BD25);
    c[1] = ^(d & 32'hDEBA_8050);
    c[2] = ^(d & 32'h413D_89AA);
    c[3] = ^(d & 32'h3123_4ED1);
    c[4] = ^(d & 32'hC2C1_323B);
    c[5] = ^(d & 32'h2DCC_624C);
    c[6] = ^(d & 32'h9850_5586);
    return c ^ 7'h2A;
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (32'(p) == MaxOutstanding - 1) ? '0 : p + 1'b1;
  endfunction

  logic [31:0]     mem_q       [Depth];
  logic [31:0]     fifo_data_q [MaxOutstanding];
  logic            fifo_err_q  [MaxOutstanding];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [15:0]     err_cnt_q, err_cnt_d;

  logic            push, pop, in_range;
  logic [31:0]     offset, push_data;
  logic [IdxW-1:0] idx;

  // Request decode: the unsigned offset compare rejects addresses below BaseAddr without wrapping.
  always_comb begin
    offset    = instr_addr_i - BaseAddr;
    in_range  = (instr_addr_i >= BaseAddr) && ({1'b0, offset} < Span);
    idx       = offset[IdxW+1:2];
    push_data = in_range ? mem_q[idx] : 32'h0;
  end

  assign instr_gnt_o = instr_req_i && !stall_i && !rst_i && (cnt_q < MaxCnt);
  assign push        = instr_gnt_o;
  assign pop         = (cnt_q != 3'd0);

  always_comb begin
    rd_ptr_d  = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    cnt_d     = cnt_q + 3'(push) - 3'(pop);
    err_cnt_d = err_cnt_q;
    if (pop && fifo_err_q[rd_ptr_q] && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Store and FIFO payload carry no reset; the store read above samples the pre-write word.
  always_ff @(posedge clk_i) begin
    if (load_we_i) begin
      mem_q[load_addr_i] <= load_data_i;
    end
    if (push) begin
      fifo_data_q[wr_ptr_q] <= push_data;
      fifo_err_q[wr_ptr_q]  <= !in_range;
    end
  end

  // Response stage: FIFO head is presented whenever non-empty, zeroed otherwise.
  assign instr_rvalid_o     = pop;
  assign instr_rdata_o      = pop ? fifo_data_q[rd_ptr_q] : 32'h0;
  assign instr_err_o        = pop ? fifo_err_q[rd_ptr_q] : 1'b0;
  assign instr_rdata_intg_o = secded_inv_enc(instr_rdata_o);
  assign err_count_o        = err_cnt_q;

endmodule

// File: tb/tb_ibex_instr_responder.sv
// Randomised and directed bench for ibex_instr_responder against a queue-based response model.
module tb_ibex_instr_responder;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst, req, stall, we;
  logic [31:0] addr, ldata;
  logic [7:0]  laddr;
  logic        gnt, rvalid, err;
  logic [31:0] rdata;
  logic [6:0]  intg;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  ibex_instr_responder #(.Depth(DEPTH), .BaseAddr(BASE), .MaxOutstanding(MAXO)) dut (
    .clk_i(clk), .rst_i(rst), .instr_req_i(req), .instr_addr_i(addr), .instr_gnt_o(gnt),
    .instr_rvalid_o(rvalid), .instr_rdata_o(rdata), .instr_rdata_intg_o(intg),
    .instr_err_o(err), .stall_i(stall), .load_we_i(we), .load_addr_i(laddr),
    .load_data_i(ldata), .err_count_o(err_count)
  );

  typedef struct { logic e; logic [31:0] d; } resp_t;
  resp_t       q[$];
  logic [31:0] mem_m [DEPTH];
  int unsigned errc_m;
  int          vectors = 0, miscompares = 0;
  int          gnt_n = 0, rv_n = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_intg(input logic [31:0] d);
    logic [31:0] masks [7];
    logic [6:0]  c;
    masks = '{32'h2606_BD25, 32'hDEBA_8050, 32'h413D_89AA, 32'h3123_4ED1,
              32'hC2C1_323B, 32'h2DCC_624C, 32'h9850_5586};
    for (int i = 0; i < 7; i++) begin
      c[i] = 1'b0;
      for (int b = 0; b < 32; b++) if (masks[i][b]) c[i] = c[i] ^ d[b];
    end
    return c ^ 7'b010_1010;
  endfunction

  // One clock cycle: drive inputs, check outputs at the falling edge, then advance the model.
  task automatic step(input logic r, input logic [31:0] a, input logic s,
                      input logic w, input logic [7:0] la, input logic [31:0] ld);
    logic        exp_g, inr;
    logic [31:0] exp_d;
    longint      la64;
    resp_t       n;
    req = r; addr = a; stall = s; we = w; laddr = la; ldata = ld;
    @(negedge clk);
    exp_g = r && !s && (q.size() < MAXO);
    chk("gnt", 32'(gnt), 32'(exp_g));
    chk("rvalid", 32'(rvalid), 32'(q.size() > 0));
    exp_d = (q.size() > 0) ? q[0].d : 32'h0;
    chk("rdata", rdata, exp_d);
    chk("err", 32'(err), (q.size() > 0) ? 32'(q[0].e) : 32'h0);
    chk("intg", 32'(intg), 32'(ref_intg(exp_d)));
    chk("err_count", 32'(err_count), errc_m);
    if (gnt) gnt_n++;
    if (rvalid) rv_n++;
    if (q.size() > 0) begin
      if (q[0].e && errc_m < 32'hFFFF) errc_m++;
      void'(q.pop_front());
    end
    if (exp_g) begin
      la64 = longint'(a);
      inr  = (la64 >= longint'(BASE)) && (la64 < longint'(BASE) + 4 * DEPTH);
      n.e  = !inr;
      n.d  = inr ? mem_m[(la64 - longint'(BASE)) / 4] : 32'h0;
      q.push_back(n);
    end
    if (w) mem_m[la] = ld;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = 1'b1; stall = 1'b0; we = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_err_count", 32'(err_count), 32'h0);
    gnt_n -= q.size();
    q.delete();
    errc_m = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned k;
    k = $urandom_range(0, 9);
    case (k)
      7:       return BASE - 32'(4 * $urandom_range(1, 8));
      8:       return BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 8));
      9:       return 32'hFFFF_FFFC;
      default: return BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    rst = 1'b1; req = 1'b0; stall = 1'b0; we = 1'b0; addr = '0; laddr = '0; ldata = '0;
    errc_m = 0;
    #1;
    chk("init_rvalid", 32'(rvalid), 32'h0);
    chk("init_gnt", 32'(gnt), 32'h0);
    chk("init_err_count", 32'(err_count), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b0, 1'b1, 8'(i), $urandom);

    // Directed: sequential fetches of a small program.
    step(1'b0, '0, 1'b0, 1'b1, 8'd0, 32'h0000_0013);
    step(1'b0, '0, 1'b0, 1'b1, 8'd1, 32'h1);
    step(1'b0, '0, 1'b0, 1'b1, 8'd2, 32'h2);
    step(1'b0, '0, 1'b0, 1'b1, 8'd3, 32'h3);
    for (int i = 0; i < 4; i++) step(1'b1, BASE + 32'(4 * i), 1'b0, 1'b0, '0, '0);
    step(1'b0, '0, 1'b0, 1'b0, '0, '0);
    step(1'b0, '0, 1'b0, 1'b0, '0, '0);

    // Directed: stall holds off grant.
    for (int i = 0; i < 3; i++) step(1'b1, BASE + 32'h8, 1'b1, 1'b0, '0, '0);
    step(1'b1, BASE + 32'h8, 1'b0, 1'b0, '0, '0);
    step(1'b0, '0, 1'b0, 1'b0, '0, '0);

    // Directed: out-of-range fetches.
    do_reset();
    step(1'b1, 32'h7FFF_FFFC, 1'b0, 1'b0, '0, '0);
    step(1'b1, 32'h8000_0400, 1'b0, 1'b0, '0, '0);
    step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, '0, '0);
    step(1'b0, '0, 1'b0, 1'b0, '0, '0);
    step(1'b0, '0, 1'b0, 1'b0, '0, '0);
    chk("err_count_3", 32'(err_count), 32'd3);

    // Directed: same-cycle load and fetch of word 5.
    step(1'b0, '0, 1'b0, 1'b1, 8'd5, 32'hAAAA_0005);
    step(1'b1, 32'h8000_0014, 1'b0, 1'b1, 8'd5, 32'hBBBB_0005);
    step(1'b1, 32'h8000_0014, 1'b0, 1'b0, '0, '0);
    step(1'b0, '0, 1'b0, 1'b0, '0, '0);

    // Directed: reset with responses in flight, store survives.
    step(1'b1, BASE, 1'b0, 1'b0, '0, '0);
    step(1'b1, BASE + 32'h4, 1'b0, 1'b0, '0, '0);
    do_reset();
    step(1'b0, '0, 1'b0, 1'b0, '0, '0);
    step(1'b0, '0, 1'b0, 1'b0, '0, '0);
    step(1'b1, BASE, 1'b0, 1'b0, '0, '0);
    step(1'b0, '0, 1'b0, 1'b0, '0, '0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 63) == 0) do_reset();
      else step($urandom_range(0, 9) < 8, rand_addr(), $urandom_range(0, 3) == 0,
                $urandom_range(0, 9) == 0, 8'($urandom), $urandom);
    end
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0, '0, '0);
    chk("rvalid_vs_gnt", 32'(rv_n), 32'(gnt_n));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
